// File: rtl/gray_checker.sv
// Checks a Gray-coded counter stream: decodes it, flags illegal steps and bad overflow flags.
// Outputs register one edge after an accepted sample; no backpressure, samples are taken whenever En=1.
module gray_checker #(
    parameter int WIDTH = 3,
    parameter int CNT_W = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             En,
    input  logic [WIDTH-1:0] Gray,
    input  logic             Ovf_in,
    input  logic             Clr,
    output logic [WIDTH-1:0] Bin,
    output logic             Err,
    output logic             Err_sticky,
    output logic [CNT_W-1:0] Err_cnt,
    output logic [CNT_W-1:0] Wrap_cnt,
    output logic             Locked
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        ERROR = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       rst_sync_q;
    logic [WIDTH-1:0] bin_q, bin_d;
    logic             err_q, err_d;
    logic             sticky_q, sticky_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [CNT_W-1:0] wrap_cnt_q, wrap_cnt_d;

    logic [WIDTH-1:0] dec;
    logic [WIDTH-1:0] ref_gray;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] flips;
    logic             one_flip;
    logic             legal_step;
    logic             step_bad;
    logic             ovf_bad;
    logic             wrap_hit;
    logic             accept;

    // Reset asserts asynchronously but its release only reaches the FSM two edges later.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    always_comb begin
        dec            = '0;
        dec[WIDTH-1]   = Gray[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            dec[i] = dec[i+1] ^ Gray[i];
        end
    end

    // The reference is the last accepted sample; its Gray form is re-derived from bin_q.
    assign ref_gray   = bin_q ^ (bin_q >> 1);
    assign diff       = dec - bin_q;
    assign flips      = Gray ^ ref_gray;
    assign one_flip   = (flips != '0) && ((flips & (flips - WIDTH'(1))) == '0);
    assign legal_step = (diff == WIDTH'(1)) && one_flip;
    assign step_bad   = (diff != '0) && !legal_step;
    assign ovf_bad    = Ovf_in != (&dec);
    assign wrap_hit   = legal_step && (&bin_q);
    assign accept     = En && rst_sync_q[1];

    always_comb begin
        state_d    = state_q;
        bin_d      = bin_q;
        err_d      = 1'b0;
        sticky_d   = sticky_q;
        err_cnt_d  = err_cnt_q;
        wrap_cnt_d = wrap_cnt_q;

        if (Clr) begin
            state_d    = IDLE;
            bin_d      = '0;
            sticky_d   = 1'b0;
            err_cnt_d  = '0;
            wrap_cnt_d = '0;
        end else if (accept) begin
            bin_d = dec;
            if (state_q == IDLE) begin
                state_d = TRACK;
            end else begin
                if (step_bad || ovf_bad) begin
                    err_d    = 1'b1;
                    sticky_d = 1'b1;
                    state_d  = ERROR;
                    if (err_cnt_q != '1) begin
                        err_cnt_d = err_cnt_q + CNT_W'(1);
                    end
                end
                // A legal wrap is counted even when the same sample carries a bad overflow flag.
                if (wrap_hit && (wrap_cnt_q != '1)) begin
                    wrap_cnt_d = wrap_cnt_q + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q    <= IDLE;
            bin_q      <= '0;
            err_q      <= 1'b0;
            sticky_q   <= 1'b0;
            err_cnt_q  <= '0;
            wrap_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            bin_q      <= bin_d;
            err_q      <= err_d;
            sticky_q   <= sticky_d;
            err_cnt_q  <= err_cnt_d;
            wrap_cnt_q <= wrap_cnt_d;
        end
    end

    assign Bin        = bin_q;
    assign Err        = err_q;
    assign Err_sticky = sticky_q;
    assign Err_cnt    = err_cnt_q;
    assign Wrap_cnt   = wrap_cnt_q;
    assign Locked     = (state_q == TRACK);

endmodule

// File: tb/tb_gray_checker.sv
// Bench for gray_checker: hand-written vector table, corner sequences, and random traffic
// compared against a rule-level model of the checker.
module tb_gray_checker;

    localparam int W    = 3;
    localparam int MAXV = (1 << W) - 1;
    localparam int CMAX = 255;

    logic         Clk = 1'b0;
    logic         Reset;
    logic         En;
    logic [W-1:0] Gray;
    logic         Ovf_in;
    logic         Clr;
    logic [W-1:0] Bin;
    logic         Err;
    logic         Err_sticky;
    logic [7:0]   Err_cnt;
    logic [7:0]   Wrap_cnt;
    logic         Locked;

    int n_checks = 0;
    int n_fail   = 0;

    gray_checker #(.WIDTH(W), .CNT_W(8)) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .En         (En),
        .Gray       (Gray),
        .Ovf_in     (Ovf_in),
        .Clr        (Clr),
        .Bin        (Bin),
        .Err        (Err),
        .Err_sticky (Err_sticky),
        .Err_cnt    (Err_cnt),
        .Wrap_cnt   (Wrap_cnt),
        .Locked     (Locked)
    );

    always #5 Clk = ~Clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Rule-level model: the last accepted sample and the error/wrap bookkeeping.
    bit m_have_ref;
    int m_ref_val, m_ref_gray;
    int m_bin, m_err, m_sticky, m_errcnt, m_wrapcnt;

    function automatic int g2b(input int g);
        int b = 0;
        for (int s = 0; s < W; s++) b = b ^ (g >> s);
        return b & MAXV;
    endfunction

    task automatic model_reset();
        m_have_ref = 0; m_ref_val = 0; m_ref_gray = 0;
        m_bin = 0; m_err = 0; m_sticky = 0; m_errcnt = 0; m_wrapcnt = 0;
    endtask

    task automatic model_step(input int en, input int clr, input int g, input int ovf);
        int b, d, ham;
        bit legal;
        m_err = 0;
        if (clr != 0) begin
            m_have_ref = 0; m_bin = 0; m_sticky = 0; m_errcnt = 0; m_wrapcnt = 0;
        end else if (en != 0) begin
            b = g2b(g);
            if (m_have_ref) begin
                d     = (b - m_ref_val + (MAXV + 1)) % (MAXV + 1);
                ham   = $countones(g ^ m_ref_gray);
                legal = (d == 1) && (ham == 1);
                if (!(d == 0 || legal) || (ovf != (b == MAXV ? 1 : 0))) begin
                    m_err = 1; m_sticky = 1;
                    if (m_errcnt < CMAX) m_errcnt++;
                end
                if (legal && m_ref_val == MAXV && m_wrapcnt < CMAX) m_wrapcnt++;
            end
            m_have_ref = 1; m_ref_val = b; m_ref_gray = g; m_bin = b;
        end
    endtask

    task automatic cmp(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_model(input string tag);
        cmp({tag, " Bin"}, Bin, m_bin);
        cmp({tag, " Err"}, Err, m_err);
        cmp({tag, " Err_sticky"}, Err_sticky, m_sticky);
        cmp({tag, " Err_cnt"}, Err_cnt, m_errcnt);
        cmp({tag, " Wrap_cnt"}, Wrap_cnt, m_wrapcnt);
        cmp({tag, " Locked"}, Locked, (m_have_ref && !m_sticky) ? 1 : 0);
    endtask

    task automatic drive(input logic en, input logic clr, input logic [W-1:0] g,
                         input logic ovf, input string tag);
        En = en; Clr = clr; Gray = g; Ovf_in = ovf;
        @(posedge Clk);
        #1;
        model_step(en, clr, g, ovf);
        check_model(tag);
    endtask

    typedef struct {
        logic         en, clr;
        logic [W-1:0] gray;
        logic         ovf;
        logic [W-1:0] bin;
        logic         err, locked;
        int           ec, wc;
    } vec_t;
    vec_t tbl[$];

    task automatic add(input logic en, input logic clr, input logic [W-1:0] g, input logic ovf,
                       input logic [W-1:0] b, input logic err, input logic lk, input int ec, input int wc);
        vec_t v;
        v.en = en; v.clr = clr; v.gray = g; v.ovf = ovf;
        v.bin = b; v.err = err; v.locked = lk; v.ec = ec; v.wc = wc;
        tbl.push_back(v);
    endtask

    initial begin
        int cur_b;
        logic en_r, clr_r, ovf_r;

        Reset = 1'b0; En = 1'b0; Clr = 1'b0; Gray = '0; Ovf_in = 1'b0;
        model_reset();
        #2;
        check_model("reset");
        #10 Reset = 1'b1;
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 3'b000, 1'b0, "sync window");

        // Ovf_in is legitimately high only when the decoded value is all ones (Gray 100).
        //   en clr gray    ovf   bin   err lk ec wc
        add(1, 0, 3'b000, 0, 3'b000, 0, 1, 0, 0);  // capture, no check
        add(1, 0, 3'b001, 0, 3'b001, 0, 1, 0, 0);
        add(1, 0, 3'b011, 0, 3'b010, 0, 1, 0, 0);
        add(1, 0, 3'b010, 0, 3'b011, 0, 1, 0, 0);
        add(1, 0, 3'b110, 0, 3'b100, 0, 1, 0, 0);
        add(1, 0, 3'b111, 0, 3'b101, 0, 1, 0, 0);
        add(1, 0, 3'b101, 0, 3'b110, 0, 1, 0, 0);
        add(1, 0, 3'b100, 1, 3'b111, 0, 1, 0, 0);
        add(1, 0, 3'b000, 0, 3'b000, 0, 1, 0, 1);  // legal wrap
        add(1, 0, 3'b001, 0, 3'b001, 0, 1, 0, 1);
        add(1, 0, 3'b011, 0, 3'b010, 0, 1, 0, 1);
        add(1, 0, 3'b110, 0, 3'b100, 1, 0, 1, 1);  // jump by two
        add(1, 0, 3'b111, 0, 3'b101, 0, 0, 1, 1);  // legal step while in ERROR
        add(1, 0, 3'b100, 0, 3'b111, 1, 0, 2, 1);  // step and overflow error merged
        add(1, 0, 3'b000, 1, 3'b000, 1, 0, 3, 2);  // legal wrap, bad overflow flag
        add(1, 0, 3'b001, 0, 3'b001, 0, 0, 3, 2);
        add(1, 0, 3'b011, 0, 3'b010, 0, 0, 3, 2);
        for (int i = 0; i < 5; i++) add(1, 0, 3'b010, 0, 3'b011, 0, 0, 3, 2);  // step then stalls
        add(0, 0, 3'b110, 0, 3'b011, 0, 0, 3, 2);
        add(0, 0, 3'b101, 1, 3'b011, 0, 0, 3, 2);
        add(0, 0, 3'b111, 0, 3'b011, 0, 0, 3, 2);
        add(1, 1, 3'b101, 0, 3'b000, 0, 0, 0, 0);  // Clr wins over En
        add(1, 0, 3'b110, 0, 3'b100, 0, 1, 0, 0);  // fresh capture after Clr

        for (int i = 0; i < tbl.size(); i++) begin
            En = tbl[i].en; Clr = tbl[i].clr; Gray = tbl[i].gray; Ovf_in = tbl[i].ovf;
            @(posedge Clk);
            #1;
            model_step(tbl[i].en, tbl[i].clr, tbl[i].gray, tbl[i].ovf);
            cmp($sformatf("tbl[%0d] Bin", i), Bin, tbl[i].bin);
            cmp($sformatf("tbl[%0d] Err", i), Err, tbl[i].err);
            cmp($sformatf("tbl[%0d] Locked", i), Locked, tbl[i].locked);
            cmp($sformatf("tbl[%0d] Err_cnt", i), Err_cnt, tbl[i].ec);
            cmp($sformatf("tbl[%0d] Wrap_cnt", i), Wrap_cnt, tbl[i].wc);
        end

        // 300 consecutive errors saturate the error counter.
        for (int k = 0; k < 300; k++)
            drive(1'b1, 1'b0, (k % 2 == 1) ? 3'b011 : 3'b000, 1'b0, "err storm");
        cmp("err sat Err_cnt", Err_cnt, 255);
        cmp("err sat Err_sticky", Err_sticky, 1);
        cmp("err sat Locked", Locked, 0);
        drive(1'b1, 1'b1, 3'b001, 1'b0, "clr with en");
        cmp("clr Err_cnt", Err_cnt, 0);
        cmp("clr Err_sticky", Err_sticky, 0);
        cmp("clr Locked", Locked, 0);
        cmp("clr Bin", Bin, 0);
        drive(1'b1, 1'b0, 3'b111, 1'b0, "capture after clr");
        cmp("capture after clr Err", Err, 0);
        cmp("capture after clr Bin", Bin, 5);

        // 260 full laps saturate the wrap counter.
        drive(1'b0, 1'b1, 3'b000, 1'b0, "clr before laps");
        for (int k = 0; k < 8 * 260; k++) begin
            int b;
            b = k % 8;
            drive(1'b1, 1'b0, 3'(b ^ (b >> 1)), (b == MAXV), "laps");
        end
        cmp("wrap sat Wrap_cnt", Wrap_cnt, 255);
        cmp("wrap sat Err_cnt", Err_cnt, 0);

        cur_b = 0;
        for (int k = 0; k < 3000; k++) begin
            int a;
            en_r  = ($urandom_range(0, 9) != 0);
            clr_r = ($urandom_range(0, 199) == 0);
            a = $urandom_range(0, 9);
            if (a < 6)      cur_b = (cur_b + 1) & MAXV;
            else if (a > 7) cur_b = $urandom_range(0, MAXV);
            ovf_r = (cur_b == MAXV);
            if ($urandom_range(0, 19) == 0) ovf_r = !ovf_r;
            drive(en_r, clr_r, 3'(cur_b ^ (cur_b >> 1)), ovf_r, "random");
        end

        // Reset pulled between edges mid-stream, then a fresh capture after release.
        drive(1'b1, 1'b0, 3'b011, 1'b0, "pre-reset");
        drive(1'b1, 1'b0, 3'b000, 1'b0, "pre-reset");
        #2 Reset = 1'b0;
        #1;
        model_reset();
        check_model("async reset");
        cmp("async reset Bin", Bin, 0);
        drive(1'b0, 1'b0, 3'b010, 1'b0, "in reset");
        #2 Reset = 1'b1;
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 3'b000, 1'b0, "post-reset sync");
        drive(1'b1, 1'b0, 3'b101, 1'b0, "post-reset capture");
        cmp("post-reset Bin", Bin, 6);
        cmp("post-reset Err", Err, 0);
        cmp("post-reset Locked", Locked, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
